// File: rtl/spike_decoder.sv
// Spike decoder: latches the first 1->0 fall per line across one volley, rebuilds pixel = (TIME_PERIOD - t) * DIV.
// Latency: out_valid rises 1 cycle after the timestep with cycle == TIME_PERIOD-1.
// Backpressure: HOLD keeps the outputs until out_ready; a volley starting while held and not accepted is dropped and sets overrun.
//
// Ports:
//   clk, rst_n   clock; asynchronous active-low reset
//   spikes       per-line spike inputs, idle high
//   cycle        shared timestep counter
//   volley       high for the whole volley (cycle 0 .. TIME_PERIOD-1)
//   out_times    per-line spike time, line i at [i*TW +: TW]; TIME_PERIOD means no spike
//   out_pixels   per-line reconstructed intensity, line i at [i*SIZE +: SIZE]
//   out_valid    decoded volley available
//   out_ready    the consumer accepts when out_valid && out_ready
//   overrun      sticky flag, set when a volley was dropped
module spike_decoder #(
   parameter  int N_LINES     = 3,
   parameter  int TIME_PERIOD = 8,
   parameter  int SIZE        = 8,
   localparam int TW          = $clog2(TIME_PERIOD + 1),
   localparam int CW          = (TIME_PERIOD > 1) ? $clog2(TIME_PERIOD) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_LINES-1:0]      spikes,
   input  logic [CW-1:0]           cycle,
   input  logic                    volley,
   output logic [N_LINES*TW-1:0]   out_times,
   output logic [N_LINES*SIZE-1:0] out_pixels,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    overrun
);

   localparam int DIV = ((1 << SIZE) - 1) / TIME_PERIOD;

   typedef enum logic [1:0] {IDLE, CAPTURE, HOLD} state_t;

   state_t                         state;
   logic [N_LINES-1:0]             latched;
   logic [N_LINES-1:0][TW-1:0]     cap_t;

   logic                           vol_start;
   logic                           start_now;
   logic                           sample;
   logic                           end_now;
   logic [N_LINES-1:0]             base_lat;
   logic [N_LINES-1:0]             nxt_lat;
   logic [N_LINES-1:0][TW-1:0]     nxt_t;
   logic [N_LINES-1:0][TW-1:0]     fin_t;
   logic [N_LINES-1:0][SIZE-1:0]   fin_pix;

   assign vol_start = volley && (cycle == '0);
   // A start is taken from IDLE, or from HOLD when the held result is being accepted this same cycle.
   assign start_now = vol_start && ((state == IDLE) || ((state == HOLD) && out_ready));
   assign sample    = start_now || ((state == CAPTURE) && volley);
   assign end_now   = sample && (cycle == CW'(TIME_PERIOD - 1));

   always_comb begin
      // The first sample of a volley starts from a clean slate so no flags leak in from earlier volleys.
      base_lat = start_now ? '0 : latched;
      nxt_lat  = base_lat;
      nxt_t    = start_now ? '0 : cap_t;
      fin_t    = '0;
      fin_pix  = '0;
      for (int i = 0; i < N_LINES; i++) begin
         if (!base_lat[i] && !spikes[i]) begin
            nxt_lat[i] = 1'b1;
            nxt_t[i]   = TW'(cycle);
         end
         fin_t[i]   = nxt_lat[i] ? nxt_t[i] : TW'(TIME_PERIOD);
         fin_pix[i] = SIZE'((TIME_PERIOD - int'(fin_t[i])) * DIV);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         latched    <= '0;
         cap_t      <= '0;
         out_times  <= '0;
         out_pixels <= '0;
         out_valid  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         if ((state == HOLD) && out_ready) begin
            out_valid <= 1'b0;
         end
         if ((state == HOLD) && !out_ready && vol_start) begin
            overrun <= 1'b1;
         end

         if (sample) begin
            if (end_now) begin
               out_times  <= fin_t;
               out_pixels <= fin_pix;
               out_valid  <= 1'b1;
               state      <= HOLD;
               latched    <= '0;
               cap_t      <= '0;
            end else begin
               state      <= CAPTURE;
               latched    <= nxt_lat;
               cap_t      <= nxt_t;
            end
         end else if (state == CAPTURE) begin
            // volley fell before the last timestep: discard the partial capture
            state   <= IDLE;
            latched <= '0;
            cap_t   <= '0;
         end else if ((state == HOLD) && out_ready) begin
            state <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_spike_decoder.sv
module tb_spike_decoder;

   logic        clk;
   logic        rst_n;
   logic [2:0]  spikes;
   logic [2:0]  cycle;
   logic        volley;
   logic [11:0] out_times;
   logic [23:0] out_pixels;
   logic        out_valid;
   logic        out_ready;
   logic        overrun;

   int n_cmp;
   int n_fail;

   logic early;
   logic v0;

   spike_decoder #(.N_LINES(3), .TIME_PERIOD(8), .SIZE(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .spikes     (spikes),
      .cycle      (cycle),
      .volley     (volley),
      .out_times  (out_times),
      .out_pixels (out_pixels),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .overrun    (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drives one full thermometer volley; line i falls at t_i (8 = never).
   task automatic full_volley(input int ta, input int tb, input int tc,
                              output logic early_o, output logic v0_o);
      early_o = 1'b0;
      v0_o    = 1'b0;
      for (int c = 0; c < 8; c++) begin
         volley = 1'b1;
         cycle  = 3'(c);
         spikes = {(c < tc), (c < tb), (c < ta)};
         @(posedge clk);
         #1;
         if (c == 0) v0_o = out_valid;
         if (c < 7) early_o = early_o | out_valid;
      end
      volley = 1'b0;
      cycle  = 3'd0;
      spikes = 3'b111;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      idle(2);
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
      n_cmp++; if (out_times !== 12'h000) begin n_fail++; $display("FAIL reset_times: got %h want 000", out_times); end
      n_cmp++; if (out_pixels !== 24'h000000) begin n_fail++; $display("FAIL reset_pixels: got %h want 000000", out_pixels); end
      rst_n = 1'b1;
      idle(2);
   endtask

   task automatic test_basic;
      out_ready = 1'b1;
      full_volley(5, 8, 0, early, v0);
      n_cmp++; if (early !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b want 0", early); end
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", out_valid); end
      n_cmp++; if (out_times !== 12'h085) begin n_fail++; $display("FAIL basic_times: got %h want 085", out_times); end
      n_cmp++; if (out_pixels !== 24'hF8005D) begin n_fail++; $display("FAIL basic_pixels: got %h want f8005d", out_pixels); end
      idle(1);
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_one_cycle: got %b want 0", out_valid); end
   endtask

   task automatic test_glitch;
      logic [7:0] l0;
      l0 = 8'b0011_0111; // bit c = line0 value at cycle c: 1,1,1,0,1,1,0,0
      out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         volley = 1'b1;
         cycle  = 3'(c);
         spikes = {1'b1, (c < 7), l0[c]};
         @(posedge clk);
         #1;
      end
      volley = 1'b0;
      spikes = 3'b111;
      cycle  = 3'd0;
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL glitch_valid: got %b want 1", out_valid); end
      n_cmp++; if (out_times !== 12'h873) begin n_fail++; $display("FAIL glitch_times: got %h want 873", out_times); end
      n_cmp++; if (out_pixels !== 24'h001F9B) begin n_fail++; $display("FAIL glitch_pixels: got %h want 001f9b", out_pixels); end
      idle(2);
   endtask

   task automatic test_backpressure;
      out_ready = 1'b0;
      full_volley(1, 2, 3, early, v0);
      for (int k = 0; k < 5; k++) begin
         n_cmp++;
         if ({out_valid, out_times, out_pixels} !== {1'b1, 12'h321, 24'h9BBAD9}) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: got v=%b t=%h p=%h want v=1 t=321 p=9bbad9", k, out_valid, out_times, out_pixels);
         end
         idle(1);
      end
      out_ready = 1'b1;
      idle(1);
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got %b want 0", out_valid); end
      full_volley(0, 4, 7, early, v0);
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_next_valid: got %b want 1", out_valid); end
      n_cmp++; if (out_times !== 12'h740) begin n_fail++; $display("FAIL bp_next_times: got %h want 740", out_times); end
      n_cmp++; if (out_pixels !== 24'h1F7CF8) begin n_fail++; $display("FAIL bp_next_pixels: got %h want 1f7cf8", out_pixels); end
      idle(2);
   endtask

   task automatic test_overrun;
      out_ready = 1'b0;
      full_volley(2, 8, 6, early, v0);
      full_volley(0, 0, 0, early, v0);
      n_cmp++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b want 1", overrun); end
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid: got %b want 1", out_valid); end
      n_cmp++; if (out_times !== 12'h682) begin n_fail++; $display("FAIL ovr_times: got %h want 682", out_times); end
      n_cmp++; if (out_pixels !== 24'h3E00BA) begin n_fail++; $display("FAIL ovr_pixels: got %h want 3e00ba", out_pixels); end
      out_ready = 1'b1;
      idle(1);
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_drain: got %b want 0", out_valid); end
      n_cmp++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      idle(1);
      n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_cleared: got %b want 0", overrun); end
   endtask

   task automatic test_back_to_back;
      out_ready = 1'b0;
      full_volley(2, 8, 6, early, v0);
      n_cmp++; if (out_times !== 12'h682) begin n_fail++; $display("FAIL b2b_first_times: got %h want 682", out_times); end
      out_ready = 1'b1;
      full_volley(4, 1, 8, early, v0);
      n_cmp++; if (v0 !== 1'b0) begin n_fail++; $display("FAIL b2b_first_accepted: got %b want 0", v0); end
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b want 1", out_valid); end
      n_cmp++; if (out_times !== 12'h814) begin n_fail++; $display("FAIL b2b_times: got %h want 814", out_times); end
      n_cmp++; if (out_pixels !== 24'h00D97C) begin n_fail++; $display("FAIL b2b_pixels: got %h want 00d97c", out_pixels); end
      n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
      idle(2);
   endtask

   task automatic test_abort;
      logic seen;
      seen = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         volley = 1'b1;
         cycle  = 3'(c);
         spikes = 3'b000;
         @(posedge clk);
         #1;
         seen = seen | out_valid;
      end
      volley = 1'b0;
      cycle  = 3'd4;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #1;
         seen = seen | out_valid;
      end
      spikes = 3'b111;
      cycle  = 3'd0;
      n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_valid: got %b want 0", seen); end
      full_volley(8, 5, 3, early, v0);
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL abort_next_valid: got %b want 1", out_valid); end
      n_cmp++; if (out_times !== 12'h358) begin n_fail++; $display("FAIL abort_next_times: got %h want 358", out_times); end
      n_cmp++; if (out_pixels !== 24'h9B5D00) begin n_fail++; $display("FAIL abort_next_pixels: got %h want 9b5d00", out_pixels); end
      idle(2);
   endtask

   task automatic test_async_reset;
      out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         volley = 1'b1;
         cycle  = 3'(c);
         spikes = 3'b000;
         @(posedge clk);
         #1;
      end
      cycle = 3'd3;
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b want 0", out_valid); end
      n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL arst_overrun: got %b want 0", overrun); end
      n_cmp++; if (out_times !== 12'h000) begin n_fail++; $display("FAIL arst_times: got %h want 000", out_times); end
      n_cmp++; if (out_pixels !== 24'h000000) begin n_fail++; $display("FAIL arst_pixels: got %h want 000000", out_pixels); end
      volley = 1'b0;
      cycle  = 3'd0;
      spikes = 3'b111;
      #2;
      rst_n = 1'b1;
      idle(2);
      full_volley(6, 8, 7, early, v0);
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL arst_next_valid: got %b want 1", out_valid); end
      n_cmp++; if (out_times !== 12'h786) begin n_fail++; $display("FAIL arst_next_times: got %h want 786", out_times); end
      n_cmp++; if (out_pixels !== 24'h1F003E) begin n_fail++; $display("FAIL arst_next_pixels: got %h want 1f003e", out_pixels); end
      idle(2);
   endtask

   initial begin
      n_cmp     = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      spikes    = 3'b111;
      cycle     = 3'd0;
      volley    = 1'b0;
      out_ready = 1'b1;
      #1;
      test_reset();
      test_basic();
      test_glitch();
      test_backpressure();
      test_overrun();
      test_back_to_back();
      test_abort();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
